// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: one payload word plus control field under valid/ready,
// with synchronous flush, optional two-entry skid buffer and saturating stall counter.
module pipe_stage_reg #(
   parameter int unsigned DATA_W = 128,
   parameter int unsigned CTRL_W = 2,
   parameter int unsigned SKID   = 1,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt
);

   if (SKID == 0) begin : g_single
      logic              vld_q;
      logic [CTRL_W-1:0] ctrl_q;
      logic [DATA_W-1:0] data_q;
      logic              push;

      assign in_ready = !rst && (!vld_q || out_ready);
      assign push     = in_valid && in_ready;

      // A push with a simultaneous pop simply overwrites the entry.
      always_ff @(posedge clk) begin
         if (rst) begin
            vld_q  <= 1'b0;
            ctrl_q <= '0;
            data_q <= '0;
         end else if (flush) begin
            vld_q  <= 1'b0;
            ctrl_q <= '0;
         end else if (push) begin
            vld_q  <= 1'b1;
            ctrl_q <= in_ctrl;
            data_q <= in_data;
         end else if (out_ready) begin
            vld_q  <= 1'b0;
            ctrl_q <= '0;
         end
      end

      assign out_valid = vld_q;
      assign out_ctrl  = ctrl_q;
      assign out_data  = data_q;
      assign occupancy = {1'b0, vld_q};
   end else begin : g_skid
      typedef enum logic [1:0] {
         S_EMPTY = 2'd0,
         S_ONE   = 2'd1,
         S_TWO   = 2'd2
      } state_t;

      state_t            state_q;
      logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
      logic [DATA_W-1:0] main_data, skid_data;
      logic              rdy_q;
      logic              push, pop;

      // rdy_q sits at 1 through reset so the stage accepts on the first cycle after release.
      assign in_ready = rdy_q && !rst;
      assign push     = in_valid && in_ready;
      assign pop      = (state_q != S_EMPTY) && out_ready;

      always_ff @(posedge clk) begin
         if (rst) begin
            state_q   <= S_EMPTY;
            main_ctrl <= '0;
            skid_ctrl <= '0;
            main_data <= '0;
            skid_data <= '0;
            rdy_q     <= 1'b1;
         end else if (flush) begin
            state_q   <= S_EMPTY;
            main_ctrl <= '0;
            skid_ctrl <= '0;
            rdy_q     <= 1'b1;
         end else begin
            case (state_q)
               S_EMPTY: if (push) begin
                  state_q   <= S_ONE;
                  main_ctrl <= in_ctrl;
                  main_data <= in_data;
               end
               S_ONE: if (push && !pop) begin
                  state_q   <= S_TWO;
                  skid_ctrl <= in_ctrl;
                  skid_data <= in_data;
                  rdy_q     <= 1'b0;
               end else if (push) begin
                  main_ctrl <= in_ctrl;
                  main_data <= in_data;
               end else if (pop) begin
                  state_q   <= S_EMPTY;
                  main_ctrl <= '0;
               end
               S_TWO: if (pop) begin
                  state_q   <= S_ONE;
                  main_ctrl <= skid_ctrl;
                  main_data <= skid_data;
                  skid_ctrl <= '0;
                  rdy_q     <= 1'b1;
               end
               default: begin
                  state_q <= S_EMPTY;
                  rdy_q   <= 1'b1;
               end
            endcase
         end
      end

      assign out_valid = (state_q != S_EMPTY);
      assign out_ctrl  = main_ctrl;
      assign out_data  = main_data;
      assign occupancy = state_q;
   end

   always_ff @(posedge clk) begin
      if (rst)
         stall_cnt <= '0;
      else if (out_valid && !out_ready && stall_cnt != '1)
         stall_cnt <= stall_cnt + CNT_W'(1);
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: skid-mode vector table plus single-register
// replace and stall-counter saturation sequences.
module tb_pipe_stage_reg;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [1:0]  in_ctrl;
   logic [31:0] in_data;
   logic        flush;
   logic        out_ready;

   logic        r1, v1, r0, v0;
   logic [1:0]  c1, c0, o1, o0;
   logic [31:0] d1, d0;
   logic [15:0] s1;
   logic [3:0]  s0;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   pipe_stage_reg #(.DATA_W(32), .CTRL_W(2), .SKID(1), .CNT_W(16)) u1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r1), .in_ctrl(in_ctrl),
      .in_data(in_data), .flush(flush), .out_valid(v1), .out_ready(out_ready),
      .out_ctrl(c1), .out_data(d1), .occupancy(o1), .stall_cnt(s1)
   );

   pipe_stage_reg #(.DATA_W(32), .CTRL_W(2), .SKID(0), .CNT_W(4)) u0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r0), .in_ctrl(in_ctrl),
      .in_data(in_data), .flush(flush), .out_valid(v0), .out_ready(out_ready),
      .out_ctrl(c0), .out_data(d0), .occupancy(o0), .stall_cnt(s0)
   );

   typedef struct {
      logic        iv;
      logic [1:0]  ictl;
      logic [31:0] idat;
      logic        fl;
      logic        ordy;
      logic        ev;
      logic [1:0]  ectl;
      logic [31:0] edat;
      logic [1:0]  eocc;
      logic        erdy;
      logic [15:0] estall;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic iv, logic [1:0] ictl, logic [31:0] idat, logic fl,
                               logic ordy, logic ev, logic [1:0] ectl, logic [31:0] edat,
                               logic [1:0] eocc, logic erdy, logic [15:0] estall);
      vec_t v;
      v.iv = iv; v.ictl = ictl; v.idat = idat; v.fl = fl; v.ordy = ordy;
      v.ev = ev; v.ectl = ectl; v.edat = edat; v.eocc = eocc; v.erdy = erdy;
      v.estall = estall;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      logic [1:0] ck;
      rst = 1'b1; in_valid = 1'b1; in_ctrl = 2'b11; in_data = 32'hA5A5A5A5;
      flush = 1'b0; out_ready = 1'b0;
      repeat (3) tick();
      chk("rst_in_ready1", 32'(r1), 0);
      chk("rst_in_ready0", 32'(r0), 0);
      chk("rst_out_valid1", 32'(v1), 0);
      chk("rst_out_valid0", 32'(v0), 0);
      chk("rst_out_ctrl1", 32'(c1), 0);
      chk("rst_out_ctrl0", 32'(c0), 0);
      chk("rst_out_data1", d1, 0);
      chk("rst_occ1", 32'(o1), 0);
      chk("rst_stall1", 32'(s1), 0);
      chk("rst_stall0", 32'(s0), 0);
      rst = 1'b0; in_valid = 1'b0;
      #1;
      chk("rel_in_ready1", 32'(r1), 1);
      chk("rel_in_ready0", 32'(r0), 1);

      // Skid mode: streaming, backpressure, flush with push.
      for (int k = 1; k <= 8; k++) begin
         ck = k[0] ? 2'b01 : 2'b10;
         tbl.push_back(mk(1, ck, k, 0, 1, 1, ck, k, 1, 1, 0));
      end
      tbl.push_back(mk(1, 2'b01,  9, 0, 0, 1, 2'b10,  8, 2, 0, 1));
      tbl.push_back(mk(1, 2'b10, 10, 0, 0, 1, 2'b10,  8, 2, 0, 2));
      tbl.push_back(mk(1, 2'b10, 10, 0, 0, 1, 2'b10,  8, 2, 0, 3));
      tbl.push_back(mk(1, 2'b10, 10, 0, 0, 1, 2'b10,  8, 2, 0, 4));
      tbl.push_back(mk(1, 2'b10, 10, 0, 1, 1, 2'b01,  9, 1, 1, 4));
      tbl.push_back(mk(1, 2'b10, 10, 0, 1, 1, 2'b10, 10, 1, 1, 4));
      tbl.push_back(mk(0, 2'b00,  0, 0, 1, 0, 2'b00, 10, 0, 1, 4));
      tbl.push_back(mk(1, 2'b01, 11, 0, 0, 1, 2'b01, 11, 1, 1, 4));
      tbl.push_back(mk(1, 2'b10, 12, 0, 0, 1, 2'b01, 11, 2, 0, 5));
      tbl.push_back(mk(1, 2'b11, 13, 1, 0, 0, 2'b00, 11, 0, 1, 6));
      tbl.push_back(mk(1, 2'b10, 14, 0, 1, 1, 2'b10, 14, 1, 1, 6));
      tbl.push_back(mk(0, 2'b00,  0, 0, 1, 0, 2'b00, 14, 0, 1, 6));

      foreach (tbl[i]) begin
         in_valid = tbl[i].iv; in_ctrl = tbl[i].ictl; in_data = tbl[i].idat;
         flush = tbl[i].fl; out_ready = tbl[i].ordy;
         tick();
         chk($sformatf("v%0d_out_valid", i), 32'(v1), 32'(tbl[i].ev));
         chk($sformatf("v%0d_out_ctrl", i), 32'(c1), 32'(tbl[i].ectl));
         chk($sformatf("v%0d_out_data", i), d1, tbl[i].edat);
         chk($sformatf("v%0d_occupancy", i), 32'(o1), 32'(tbl[i].eocc));
         chk($sformatf("v%0d_in_ready", i), 32'(r1), 32'(tbl[i].erdy));
         chk($sformatf("v%0d_stall_cnt", i), 32'(s1), 32'(tbl[i].estall));
      end

      // Single-register mode: push with simultaneous pop replaces the entry.
      do_reset();
      in_valid = 1'b1; in_ctrl = 2'b01; in_data = 32'h21; out_ready = 1'b0;
      tick();
      chk("rep_first_valid", 32'(v0), 1);
      chk("rep_first_data", d0, 32'h21);
      chk("rep_first_ctrl", 32'(c0), 32'b01);
      chk("rep_full_in_ready", 32'(r0), 0);
      in_ctrl = 2'b10; in_data = 32'h22; out_ready = 1'b1;
      #1;
      chk("rep_comb_in_ready", 32'(r0), 1);
      chk("rep_old_offered", d0, 32'h21);
      tick();
      chk("rep_new_valid", 32'(v0), 1);
      chk("rep_new_data", d0, 32'h22);
      chk("rep_new_ctrl", 32'(c0), 32'b10);
      chk("rep_new_occ", 32'(o0), 1);
      in_valid = 1'b0;
      tick();
      chk("rep_drain_valid", 32'(v0), 0);
      chk("rep_drain_ctrl", 32'(c0), 0);
      chk("rep_drain_data", d0, 32'h22);
      chk("rep_drain_occ", 32'(o0), 0);

      // Stall counter saturation on the 4-bit counter.
      do_reset();
      in_valid = 1'b1; in_ctrl = 2'b01; in_data = 32'h33; out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      chk("sat_start", 32'(s0), 0);
      chk("sat_valid", 32'(v0), 1);
      repeat (14) @(posedge clk);
      #1;
      chk("sat_14", 32'(s0), 14);
      repeat (6) @(posedge clk);
      #1;
      chk("sat_cap", 32'(s0), 15);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("sat_flush_valid", 32'(v0), 0);
      chk("sat_flush_ctrl", 32'(c0), 0);
      chk("sat_flush_occ", 32'(o0), 0);
      chk("sat_flush_keep", 32'(s0), 15);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("sat_rst_clear", 32'(s0), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
